// File: rtl/sevenseg_scan_driver_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver.
// Pure declarations, no logic or latency.
// No flow control; consumed by the interface, top and decoder.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = 8'hFF;

  // Active-high gfedcba patterns. Entry 15 is listed first because this is a packed array.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/sevenseg_scan_driver_if.sv
// Score-load bus between a game core (master) and the scan driver (slave).
// Zero latency, wires only.
// load is a single-cycle strobe; load_pending reports staged data not yet shown.
interface sevenseg_scan_driver_if;
  import sevenseg_pkg::*;

  logic [NUM_DIGITS*4-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load;
  logic                    load_pending;

  modport master (output digits_in, output blank_in, output load, input load_pending);
  modport slave  (input digits_in, input blank_in, input load, output load_pending);

endinterface

// File: rtl/sevenseg_scan_driver_hex_to_7seg.sv
// Hex nibble to active-low seven-segment cathode decoder.
// Combinational, zero latency.
// No flow control.
module hex_to_7seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_n_o
);

  assign seg_n_o = ~SEG_TABLE[nib_i];

endmodule

// File: rtl/sevenseg_scan_driver.sv
// 8-digit multiplexed seven-segment scan driver with frame-aligned score updates.
// AN_Out/C_Out are registered, one cycle behind the prescaler/index.
// A load is never refused: the last load wins and is held until the next frame commit.
module sevenseg_scan_driver
  import sevenseg_pkg::*;
#(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  sevenseg_scan_driver_if.slave bus,
  output logic                  frame_tick,
  output logic [NUM_DIGITS-1:0] AN_Out,
  output logic [6:0]            C_Out
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0]           presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_DIGITS*4-1:0] stage_dig_q, stage_dig_d;
  logic [NUM_DIGITS-1:0]   stage_blank_q, stage_blank_d;
  logic [NUM_DIGITS*4-1:0] shadow_dig_q, shadow_dig_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              c_q, c_d;

  logic       slot_end;
  logic       commit;
  logic       in_guard;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg_n;

  assign slot_end = (presc_q == PRESC_LAST);
  assign commit   = slot_end && (idx_q == IDX_LAST);

  // Ghost-suppression window at the start of each slot; absent entirely when BLANK_CYCLES is 0.
  if (BLANK_CYCLES > 0) begin : g_guard
    assign in_guard = (presc_q < PW'(BLANK_CYCLES));
  end else begin : g_no_guard
    assign in_guard = 1'b0;
  end

  assign cur_nib = shadow_dig_q[{idx_q, 2'b00} +: 4];

  hex_to_7seg u_dec (
    .nib_i   (cur_nib),
    .seg_n_o (cur_seg_n)
  );

  // Slot timing: prescaler wraps every CLK_DIV cycles and steps the digit index.
  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (slot_end) begin
      presc_d = '0;
      idx_d   = idx_q + 1'b1;
    end
  end

  // Staging/shadow update: shadow only moves on the frame commit cycle, a load on that cycle bypasses staging.
  always_comb begin
    stage_dig_d    = stage_dig_q;
    stage_blank_d  = stage_blank_q;
    shadow_dig_d   = shadow_dig_q;
    shadow_blank_d = shadow_blank_q;
    pending_d      = pending_q;
    if (bus.load) begin
      stage_dig_d   = bus.digits_in;
      stage_blank_d = bus.blank_in;
    end
    if (commit) begin
      pending_d = 1'b0;
      if (bus.load) begin
        shadow_dig_d   = bus.digits_in;
        shadow_blank_d = bus.blank_in;
      end else if (pending_q) begin
        shadow_dig_d   = stage_dig_q;
        shadow_blank_d = stage_blank_q;
      end
    end else if (bus.load) begin
      pending_d = 1'b1;
    end
  end

  // Display drive: dark during the guard window or for masked digits, otherwise one anode low.
  always_comb begin
    an_d = AN_OFF;
    c_d  = SEG_BLANK;
    if (!in_guard && !shadow_blank_q[idx_q]) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
      c_d  = cur_seg_n;
    end
  end

  // State registers; reset leaves the display dark until the first commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_q        <= '0;
      idx_q          <= '0;
      stage_dig_q    <= '0;
      stage_blank_q  <= AN_OFF;
      shadow_dig_q   <= '0;
      shadow_blank_q <= AN_OFF;
      pending_q      <= 1'b0;
      an_q           <= AN_OFF;
      c_q            <= SEG_BLANK;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      stage_dig_q    <= stage_dig_d;
      stage_blank_q  <= stage_blank_d;
      shadow_dig_q   <= shadow_dig_d;
      shadow_blank_q <= shadow_blank_d;
      pending_q      <= pending_d;
      an_q           <= an_d;
      c_q            <= c_d;
    end
  end

  assign bus.load_pending = pending_q;
  assign frame_tick       = commit;
  assign AN_Out           = an_q;
  assign C_Out            = c_q;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with CLK_DIV=8, BLANK_CYCLES=2 (64-cycle frame).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// cyc counts rising edges since reset release, so cyc%64 is the frame-relative state.
module tb_sevenseg_scan_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [7:0] AN_Out;
  logic [6:0] C_Out;

  int n_vec = 0;
  int n_err = 0;
  int cyc;

  // Hand-derived expectations for digits 76543210, slot k.
  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
  logic [6:0] c_tab  [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

  sevenseg_scan_driver_if bus ();

  sevenseg_scan_driver #(
    .CLK_DIV      (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .frame_tick (frame_tick),
    .AN_Out     (AN_Out),
    .C_Out      (C_Out)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Advance to the next falling edge whose frame-relative state is s (at most 64 cycles).
  task automatic goto_slot(input int s);
    @(negedge clock);
    while ((cyc % 64) != s) @(negedge clock);
  endtask

  // One-cycle load strobe; afterwards the data inputs carry junk since they are don't-care.
  task automatic do_load(input logic [31:0] d, input logic [7:0] b);
    bus.digits_in = d;
    bus.blank_in  = b;
    bus.load      = 1'b1;
    @(negedge clock);
    bus.load      = 1'b0;
    bus.digits_in = $urandom;
    bus.blank_in  = 8'($urandom);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.load = 1'b0;
    bus.digits_in = 32'hDEADBEEF;
    bus.blank_in  = 8'h00;
    repeat (3) @(negedge clock);
    n_vec++; if (AN_Out !== 8'hFF) begin n_err++; $display("FAIL rst_an got %h want ff", AN_Out); end
    n_vec++; if (C_Out !== 7'h7F) begin n_err++; $display("FAIL rst_c got %h want 7f", C_Out); end
    n_vec++; if (bus.load_pending !== 1'b0) begin n_err++; $display("FAIL rst_pend got %b want 0", bus.load_pending); end
    n_vec++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL rst_tick got %b want 0", frame_tick); end
    reset = 1'b1;
    for (int t = 0; t < 130; t++) begin
      n_vec++; if (AN_Out !== 8'hFF) begin n_err++; $display("FAIL idle_an t=%0d got %h want ff", t, AN_Out); end
      n_vec++; if (C_Out !== 7'h7F) begin n_err++; $display("FAIL idle_c t=%0d got %h want 7f", t, C_Out); end
      n_vec++; if (frame_tick !== ((t % 64) == 63)) begin
        n_err++; $display("FAIL idle_tick t=%0d got %b want %b", t, frame_tick, (t % 64) == 63);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_load_display;
    goto_slot(20);
    do_load(32'h76543210, 8'h00);
    while (1) begin
      n_vec++; if (bus.load_pending !== 1'b1) begin n_err++; $display("FAIL pend_hold s=%0d got %b want 1", cyc % 64, bus.load_pending); end
      if ((cyc % 64) == 63) break;
      @(negedge clock);
    end
    n_vec++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL commit_tick got %b want 1", frame_tick); end
    @(negedge clock);
    n_vec++; if (bus.load_pending !== 1'b0) begin n_err++; $display("FAIL pend_clear got %b want 0", bus.load_pending); end
    for (int s = 1; s < 64; s++) begin
      @(negedge clock);
      n_vec++; if ($countones(~AN_Out) > 1) begin n_err++; $display("FAIL one_hot s=%0d got %h want <=1 low bit", s, AN_Out); end
      if ((s % 8) == 1 || (s % 8) == 2) begin
        n_vec++; if (AN_Out !== 8'hFF) begin n_err++; $display("FAIL guard_an s=%0d got %h want ff", s, AN_Out); end
        n_vec++; if (C_Out !== 7'h7F) begin n_err++; $display("FAIL guard_c s=%0d got %h want 7f", s, C_Out); end
      end
      if ((s % 8) == 3) begin
        n_vec++; if (AN_Out !== an_tab[s/8]) begin n_err++; $display("FAIL digit_an s=%0d got %h want %h", s, AN_Out, an_tab[s/8]); end
        n_vec++; if (C_Out !== c_tab[s/8]) begin n_err++; $display("FAIL digit_c s=%0d got %h want %h", s, C_Out, c_tab[s/8]); end
      end
    end
    @(negedge clock);
    n_vec++; if (AN_Out !== 8'h7F) begin n_err++; $display("FAIL slot7_tail_an got %h want 7f", AN_Out); end
    n_vec++; if (C_Out !== 7'h78) begin n_err++; $display("FAIL slot7_tail_c got %h want 78", C_Out); end
  endtask

  task automatic test_blank_mask;
    goto_slot(20);
    do_load(32'hFEDCBA98, 8'hF0);
    goto_slot(0);
    for (int s = 1; s < 64; s++) begin
      @(negedge clock);
      n_vec++; if (AN_Out[7:4] !== 4'hF) begin n_err++; $display("FAIL masked_an s=%0d got %h want 4'hf upper", s, AN_Out); end
      if (s == 3) begin
        n_vec++; if (AN_Out !== 8'hFE || C_Out !== 7'h00) begin n_err++; $display("FAIL dig0_8 got %h/%h want fe/00", AN_Out, C_Out); end
      end
      if (s == 11) begin
        n_vec++; if (AN_Out !== 8'hFD || C_Out !== 7'h10) begin n_err++; $display("FAIL dig1_9 got %h/%h want fd/10", AN_Out, C_Out); end
      end
      if (s == 27) begin
        n_vec++; if (AN_Out !== 8'hF7 || C_Out !== 7'h03) begin n_err++; $display("FAIL dig3_b got %h/%h want f7/03", AN_Out, C_Out); end
      end
      if (s == 35) begin
        n_vec++; if (AN_Out !== 8'hFF || C_Out !== 7'h7F) begin n_err++; $display("FAIL dig4_dark got %h/%h want ff/7f", AN_Out, C_Out); end
      end
    end
  endtask

  task automatic test_back_to_back;
    goto_slot(10);
    do_load(32'h11111111, 8'h00);
    goto_slot(30);
    n_vec++; if (bus.load_pending !== 1'b1) begin n_err++; $display("FAIL b2b_pend1 got %b want 1", bus.load_pending); end
    do_load(32'h22222222, 8'h00);
    goto_slot(63);
    n_vec++; if (bus.load_pending !== 1'b1) begin n_err++; $display("FAIL b2b_pend2 got %b want 1", bus.load_pending); end
    @(negedge clock);
    n_vec++; if (bus.load_pending !== 1'b0) begin n_err++; $display("FAIL b2b_pend_clr got %b want 0", bus.load_pending); end
    for (int s = 1; s < 64; s++) begin
      @(negedge clock);
      if (AN_Out !== 8'hFF) begin
        n_vec++; if (C_Out !== 7'h24) begin n_err++; $display("FAIL b2b_only2 s=%0d got %h want 24", s, C_Out); end
      end
      if ((s % 8) == 3) begin
        n_vec++; if (AN_Out !== an_tab[s/8]) begin n_err++; $display("FAIL b2b_an s=%0d got %h want %h", s, AN_Out, an_tab[s/8]); end
      end
    end
  endtask

  task automatic test_load_on_commit;
    n_vec++; if (bus.load_pending !== 1'b0) begin n_err++; $display("FAIL oc_pend_pre got %b want 0", bus.load_pending); end
    n_vec++; if (frame_tick !== 1'b1) begin n_err++; $display("FAIL oc_tick got %b want 1", frame_tick); end
    do_load(32'h00000005, 8'hFE);
    for (int s = 0; s < 64; s++) begin
      n_vec++; if (bus.load_pending !== 1'b0) begin n_err++; $display("FAIL oc_pend s=%0d got %b want 0", s, bus.load_pending); end
      if (s == 0) begin
        n_vec++; if (AN_Out !== 8'h7F || C_Out !== 7'h24) begin n_err++; $display("FAIL oc_old got %h/%h want 7f/24", AN_Out, C_Out); end
      end
      if (s == 3) begin
        n_vec++; if (AN_Out !== 8'hFE || C_Out !== 7'h12) begin n_err++; $display("FAIL oc_new got %h/%h want fe/12", AN_Out, C_Out); end
      end
      if (s == 11) begin
        n_vec++; if (AN_Out !== 8'hFF || C_Out !== 7'h7F) begin n_err++; $display("FAIL oc_dig1 got %h/%h want ff/7f", AN_Out, C_Out); end
      end
      if (s < 63) @(negedge clock);
    end
  endtask

  task automatic test_async_reset;
    do_load(32'h76543210, 8'h00);
    goto_slot(20);
    n_vec++; if (AN_Out !== 8'hFB || C_Out !== 7'h24) begin n_err++; $display("FAIL ar_pre got %h/%h want fb/24", AN_Out, C_Out); end
    do_load(32'hFFFFFFFF, 8'h00);
    n_vec++; if (bus.load_pending !== 1'b1) begin n_err++; $display("FAIL ar_pend_pre got %b want 1", bus.load_pending); end
    #2 reset = 1'b0;
    #1;
    n_vec++; if (AN_Out !== 8'hFF) begin n_err++; $display("FAIL ar_an got %h want ff", AN_Out); end
    n_vec++; if (C_Out !== 7'h7F) begin n_err++; $display("FAIL ar_c got %h want 7f", C_Out); end
    n_vec++; if (bus.load_pending !== 1'b0) begin n_err++; $display("FAIL ar_pend got %b want 0", bus.load_pending); end
    n_vec++; if (frame_tick !== 1'b0) begin n_err++; $display("FAIL ar_tick got %b want 0", frame_tick); end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int t = 0; t < 130; t++) begin
      n_vec++; if (AN_Out !== 8'hFF || C_Out !== 7'h7F) begin n_err++; $display("FAIL ar_dark t=%0d got %h/%h want ff/7f", t, AN_Out, C_Out); end
      n_vec++; if (frame_tick !== ((t % 64) == 63)) begin
        n_err++; $display("FAIL ar_tick_t t=%0d got %b want %b", t, frame_tick, (t % 64) == 63);
      end
      @(negedge clock);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_display();
    test_blank_mask();
    test_back_to_back();
    test_load_on_commit();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan_driver.md
Name: sevenseg_scan_driver

Overview:
- Multiplexed 8-digit seven-segment scan driver. It produces the active-low anode bus (AN_Out) and cathode bus (C_Out) that the game top level muxes onto the board display.
- Game cores hand it a 32-bit hex score word plus a blank mask.
- Staged updates are applied only at frame boundaries, so the display never shows a torn score.
- It includes a ghost-suppression blanking guard at the start of each digit slot.

Parameters:
- CLK_DIV, 100000, clock cycles per digit slot (1 kHz digit rate at 100 MHz); legal range >= 2.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < CLK_DIV; 0 disables blanking.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- digits_in  input  32  eight hex nibbles; nibble k = digits_in[4k+3:4k] drives AN_Out[k]; digit 0 is rightmost.
- blank_in  input  8  bit k = 1 keeps digit k dark.
- load  input  1  single-cycle strobe; captures digits_in/blank_in into staging.
- load_pending  output  1  staged data not yet committed to display.
- frame_tick  output  1  one-cycle pulse at every frame commit point.
- AN_Out  output  8  anode enables, active-low.
- C_Out  output  7  cathodes, active-low; C_Out[0]=a … C_Out[6]=g.

Behaviour:
- Reset (reset=0, async, takes effect immediately even mid-slot):
  - AN_Out=8'hFF, C_Out=7'h7F, load_pending=0, frame_tick=0.
  - Prescaler=0, digit index=0.
  - Shadow and staging digits=0; shadow and staging blank mask=8'hFF (display dark until first commit).
- Prescaler counts 0..CLK_DIV-1 and wraps. At CLK_DIV-1 the index advances by 1, wrapping 7->0.
- Commit cycle = prescaler==CLK_DIV-1 and index==7.
  - frame_tick=1 for exactly that cycle, every frame, independent of pending.
  - Frame period = 8*CLK_DIV cycles.
- Display generation (AN_Out/C_Out registered, one cycle behind prescaler/index):
  - prescaler < BLANK_CYCLES: AN_Out=8'hFF, C_Out=7'h7F.
  - Otherwise, if shadow blank[idx]=1: AN_Out=8'hFF, C_Out=7'h7F.
  - Otherwise: AN_Out=~(8'b1<<idx), C_Out=~seg(shadow nibble idx).
  - At most one AN_Out bit is low at any time.
- seg table, active-high gfedcba:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
- Load handshake:
  - load=1 on a non-commit cycle: staging <= inputs; load_pending=1 from the next cycle.
  - Load while pending: staging overwritten, last load wins, pending stays 1.
  - Commit cycle with pending=1 and no load: shadow <= staging, pending -> 0.
  - Commit cycle with load=1: shadow <= digits_in/blank_in directly (bypass), staging updated too, pending -> 0.
  - Commit cycle with pending=0 and no load: shadow unchanged.
- Shadow changes only at commit, so the new value first appears in digit 0's slot.
- Inputs digits_in/blank_in are sampled only on load cycles; they are don't-care otherwise.

Decomposition:
- Package sevenseg_pkg:
  - NUM_DIGITS=8.
  - SEG_BLANK=7'h7F, AN_OFF=8'hFF.
  - 16-entry hex-to-segment constant table above.
- Sub-module hex_to_7seg: combinational 4-bit nibble -> 7-bit active-low cathodes. Instantiated once on the muxed shadow nibble.
- Top block holds prescaler, index, staging/shadow registers, pending flag and output registers.

Test Plan (CLK_DIV=8, BLANK_CYCLES=2 unless stated):
1. Hold reset low, then release with no load:
   - AN_Out=FF, C_Out=7F during reset and for a full frame afterward.
   - frame_tick pulses every 64 cycles.
2. load digits_in=32'h76543210, blank_in=00 mid-frame:
   - load_pending=1 until the commit cycle, then 0.
   - Next frame, slot 0, after 2 dark cycles: AN_Out=FE, C_Out=7'h40.
   - Slot 1: AN_Out=FD, C_Out=7'h79.
   - Slot 7: AN_Out=7F, C_Out=7'h78.
3. Load digits 32'hFEDCBA98, blank_in=F0:
   - Digits 4-7 never assert an anode.
   - Digit 0 shows 8 (C_Out=00); digit 3 shows b (C_Out=7'h03).
4. Two loads in one frame (32'h11111111, then 32'h22222222):
   - Only 2 (C_Out=7'h24) is ever displayed.
   - pending stays 1 until commit.
5. Load asserted exactly on the commit cycle:
   - Data committed immediately; load_pending never rises.
   - Digit 0 of the next frame shows the new value.
6. Assert reset mid-slot while AN_Out=FB:
   - AN_Out=FF, C_Out=7F, pending=0 in the same cycle (async).
   - After release, display stays dark and frame timing restarts from prescaler=0, index=0.
